dec_issue_ctrl: RTL and testbench

//  Decode-stage issue sequencer that sits directly upstream of the decode->ALU pipeline buffer and drives that buffer's enable.

---
 rtl/dec_issue_ctrl.sv | 117 +++++++++++
 tb/tb_dec_issue_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dec_issue_ctrl.sv
// rtl/dec_issue_ctrl.sv - decode-stage issue sequencer (bubbles, two-word immediates, load-use, flush)
// Optional bubble counter output o_bubble_cnt enabled by `define BUBBLE_CNT_EN.
module dec_issue_ctrl #(
    parameter int IW    = 16,
    parameter int RW    = 3,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] i_instr,
    input  logic          i_instr_valid,
    input  logic          i_has_immd,
    input  logic [RW-1:0] i_rsrc1,
    input  logic [RW-1:0] i_rsrc2,
    input  logic          i_use_src1,
    input  logic          i_use_src2,
    input  logic          i_ex_mem_read,
    input  logic [RW-1:0] i_ex_rdst,
    input  logic          i_flush,
    input  logic          i_mem_stall,
    output logic [IW-1:0] o_instr,
    output logic [IW-1:0] o_immd,
    output logic          o_bubble,
    output logic          o_buf_enable,
    output logic          o_pc_hold,
    output logic          o_fd_hold,
    output logic          o_state
`ifdef BUBBLE_CNT_EN
    ,
    output logic [CNT_W-1:0] o_bubble_cnt
`endif
);

    typedef enum logic {S_DEC = 1'b0, S_IMM = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] held_instr_q, held_instr_d;
    logic          hz;

    assign hz = i_ex_mem_read &
                ((i_use_src1 & (i_ex_rdst == i_rsrc1)) |
                 (i_use_src2 & (i_ex_rdst == i_rsrc2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_DEC;
            held_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            held_instr_q <= held_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        held_instr_d = held_instr_q;
        if (!i_mem_stall) begin
            if (i_flush) begin
                state_d = S_DEC;
            end else if (i_instr_valid && !hz) begin
                case (state_q)
                    S_DEC: begin
                        if (i_has_immd) begin
                            state_d      = S_IMM;
                            held_instr_d = i_instr;
                        end
                    end
                    default: state_d = S_DEC;
                endcase
            end
        end
    end

    // Default is a bubble; only a clean issue clears it.
    always_comb begin
        o_instr      = (state_q == S_IMM) ? held_instr_q : i_instr;
        o_immd       = (state_q == S_IMM) ? i_instr : '0;
        o_bubble     = 1'b1;
        o_buf_enable = 1'b1;
        o_pc_hold    = 1'b0;
        o_fd_hold    = 1'b0;
        o_state      = state_q;
        if (rst) begin
            o_instr = '0;
            o_immd  = '0;
            o_state = 1'b0;
        end else if (i_mem_stall) begin
            o_buf_enable = 1'b0;
            o_pc_hold    = 1'b1;
            o_fd_hold    = 1'b1;
        end else if (i_flush || !i_instr_valid) begin
            o_bubble = 1'b1;
        end else if (hz) begin
            o_pc_hold = 1'b1;
            o_fd_hold = 1'b1;
        end else if (state_q == S_DEC && i_has_immd) begin
            o_bubble = 1'b1;
        end else begin
            o_bubble = 1'b0;
        end
    end

`ifdef BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (o_bubble && o_buf_enable && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// tb/tb_dec_issue_ctrl.sv - scoreboard bench for dec_issue_ctrl
module tb_dec_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_instr = '0;
    logic        i_instr_valid = 1'b0;
    logic        i_has_immd = 1'b0;
    logic [2:0]  i_rsrc1 = '0;
    logic [2:0]  i_rsrc2 = '0;
    logic        i_use_src1 = 1'b0;
    logic        i_use_src2 = 1'b0;
    logic        i_ex_mem_read = 1'b0;
    logic [2:0]  i_ex_rdst = '0;
    logic        i_flush = 1'b0;
    logic        i_mem_stall = 1'b0;
    logic [15:0] o_instr;
    logic [15:0] o_immd;
    logic        o_bubble;
    logic        o_buf_enable;
    logic        o_pc_hold;
    logic        o_fd_hold;
    logic        o_state;
`ifdef BUBBLE_CNT_EN
    logic [3:0]  o_bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] immd;
        logic        bubble;
        logic        en;
        logic        pch;
        logic        fdh;
        logic        st;
        bit          chk_bubble;
    } exp_t;

    exp_t exp_q[$];

    dec_issue_ctrl #(.IW(16), .RW(3), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr       (i_instr),
        .i_instr_valid (i_instr_valid),
        .i_has_immd    (i_has_immd),
        .i_rsrc1       (i_rsrc1),
        .i_rsrc2       (i_rsrc2),
        .i_use_src1    (i_use_src1),
        .i_use_src2    (i_use_src2),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rdst     (i_ex_rdst),
        .i_flush       (i_flush),
        .i_mem_stall   (i_mem_stall),
        .o_instr       (o_instr),
        .o_immd        (o_immd),
        .o_bubble      (o_bubble),
        .o_buf_enable  (o_buf_enable),
        .o_pc_hold     (o_pc_hold),
        .o_fd_hold     (o_fd_hold),
        .o_state       (o_state)
`ifdef BUBBLE_CNT_EN
        ,
        .o_bubble_cnt  (o_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_state"},  32'(o_state), 32'd0);
        chk({tag, "_bubble"}, 32'(o_bubble), 32'd1);
        chk({tag, "_en"},     32'(o_buf_enable), 32'd1);
        chk({tag, "_pch"},    32'(o_pc_hold), 32'd0);
        chk({tag, "_fdh"},    32'(o_fd_hold), 32'd0);
        chk({tag, "_immd"},   32'(o_immd), 32'd0);
        chk({tag, "_instr"},  32'(o_instr), 32'd0);
    endtask

    // hzm: 0 no load in EX, 1 hazard via src2, 2 load matches unused src1, 3 hazard via src1
    task automatic step(input logic [15:0] ins, input logic v, input logic hi, input int hzm,
                        input logic fl, input logic st,
                        input logic eb, input logic een, input logic eph, input logic efh,
                        input logic es, input logic [15:0] ei, input logic [15:0] eim,
                        input bit cb);
        exp_t e;
        @(posedge clk);
        #1;
        i_instr = ins; i_instr_valid = v; i_has_immd = hi;
        i_flush = fl;  i_mem_stall = st;
        i_rsrc1 = 3'd1; i_rsrc2 = 3'd2; i_use_src1 = 1'b1; i_use_src2 = 1'b1;
        i_ex_mem_read = 1'b0; i_ex_rdst = 3'd3;
        case (hzm)
            1: begin i_ex_mem_read = 1'b1; i_ex_rdst = 3'd3; i_rsrc2 = 3'd3; end
            2: begin i_ex_mem_read = 1'b1; i_ex_rdst = 3'd5; i_rsrc1 = 3'd5; i_use_src1 = 1'b0; end
            3: begin i_ex_mem_read = 1'b1; i_ex_rdst = 3'd6; i_rsrc1 = 3'd6; end
            default: ;
        endcase
        e.instr = ei; e.immd = eim; e.bubble = eb; e.en = een;
        e.pch = eph; e.fdh = efh; e.st = es; e.chk_bubble = cb;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk_bubble) chk("bubble", 32'(o_bubble), 32'(e.bubble));
            chk("buf_en", 32'(o_buf_enable), 32'(e.en));
            chk("pc_hold", 32'(o_pc_hold), 32'(e.pch));
            chk("fd_hold", 32'(o_fd_hold), 32'(e.fdh));
            chk("state", 32'(o_state), 32'(e.st));
            chk("instr", 32'(o_instr), 32'(e.instr));
            chk("immd", 32'(o_immd), 32'(e.immd));
        end
    end

    initial begin
        i_instr = 16'hABCD; i_instr_valid = 1'b1; i_has_immd = 1'b1; i_mem_stall = 1'b1;
        #2;
        chk_rst_outputs("rst0");
        repeat (2) @(posedge clk);
        #1;
        chk_rst_outputs("rst1");
        @(negedge clk);
        i_instr_valid = 1'b0; i_has_immd = 1'b0; i_mem_stall = 1'b0;
        rst = 1'b0;

        // one-word pass-through
        step(16'hA001, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA001, 16'h0000, 1);
        step(16'hA002, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA002, 16'h0000, 1);
        step(16'hA003, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA003, 16'h0000, 1);
        // two-word instruction
        step(16'h1234, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 16'h1234, 16'h0000, 1);
        step(16'hBEEF, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 16'h1234, 16'hBEEF, 1);
        step(16'hA004, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA004, 16'h0000, 1);
        // immediate word arrives late
        step(16'h5555, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 16'h5555, 16'h0000, 1);
        step(16'h0000, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 16'h5555, 16'h0000, 1);
        step(16'h6666, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 16'h5555, 16'h6666, 1);
        // load-use, then unused-source match, then src1 hazard
        step(16'h7777, 1, 0, 1, 0, 0,  1, 1, 1, 1, 0, 16'h7777, 16'h0000, 1);
        step(16'h7777, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'h7777, 16'h0000, 1);
        step(16'h7878, 1, 0, 2, 0, 0,  0, 1, 0, 0, 0, 16'h7878, 16'h0000, 1);
        step(16'h7979, 1, 0, 3, 0, 0,  1, 1, 1, 1, 0, 16'h7979, 16'h0000, 1);
        // stall, then flush with hazard, in S_IMM
        step(16'h1111, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 16'h1111, 16'h0000, 1);
        step(16'h2222, 1, 0, 1, 1, 1,  1, 0, 1, 1, 1, 16'h1111, 16'h2222, 0);
        step(16'h2222, 1, 0, 1, 1, 0,  1, 1, 0, 0, 1, 16'h1111, 16'h2222, 1);
        step(16'hA005, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA005, 16'h0000, 1);
        // hazard while holding the immediate
        step(16'h3333, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 16'h3333, 16'h0000, 1);
        step(16'h4444, 1, 0, 1, 0, 0,  1, 1, 1, 1, 1, 16'h3333, 16'h4444, 1);
        step(16'h4444, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 16'h3333, 16'h4444, 1);
        // flush beats hazard and immediate capture in S_DEC
        step(16'h1212, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 16'h1212, 16'h0000, 1);
        step(16'hA006, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA006, 16'h0000, 1);
        // async reset in the middle of S_IMM
        step(16'h9999, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 16'h9999, 16'h0000, 1);
        step(16'h8888, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 16'h9999, 16'h8888, 1);
        @(posedge clk);
        #1;
        i_instr = 16'h7777; i_instr_valid = 1'b1; i_mem_stall = 1'b1;
        rst = 1'b1;
        #1;
        chk_rst_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        chk_rst_outputs("rst_hold");
        @(negedge clk);
        i_mem_stall = 1'b0; i_instr_valid = 1'b0;
        rst = 1'b0;
        step(16'hA0A0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'hA0A0, 16'h0000, 1);

        repeat (3) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

`ifdef BUBBLE_CNT_EN
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0; i_flush = 1'b0; i_ex_mem_read = 1'b0; i_mem_stall = 1'b1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("cnt_clr", 32'(o_bubble_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_stall", 32'(o_bubble_cnt), 32'd0);
        i_mem_stall = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_5", 32'(o_bubble_cnt), 32'd5);
        repeat (15) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(o_bubble_cnt), 32'hF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
